// File: rtl/microcode_sequencer.sv
// Microcode sequencer: accepts one microcode word and issues its slots
// as pulse trains of micro-ops to the crossbar controller.
module microcode_sequencer #(
  parameter int MICROCODE_WIDTH = 64,
  parameter int SLOT_W          = 12,
  parameter int NUM_SLOTS       = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mc_valid,
  input  logic [MICROCODE_WIDTH-1:0] mc_word,
  output logic                       mc_ready,
  input  logic                       flush,
  output logic                       uop_valid,
  output logic [3:0]                 uop_op,
  output logic [3:0]                 uop_row,
  output logic                       uop_first,
  input  logic                       uop_stall,
  output logic                       done,
  output logic                       wb_en,
  output logic                       illegal
);

  localparam int NW = MICROCODE_WIDTH - SLOT_W * NUM_SLOTS - 1;
  localparam int NS = 2 ** NW;
  localparam logic [NW-1:0] NMAX = NW'(NUM_SLOTS);
  localparam logic [NW-1:0] ONE = {{(NW-1){1'b0}}, 1'b1};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                 state;
  logic [MICROCODE_WIDTH-1:0] word;
  logic [NW-1:0]              idx;
  logic [3:0]                 cnt;

  logic [SLOT_W-1:0] slot [NS];
  logic [NW-1:0]     word_n;
  logic              word_wb;
  logic [NW-1:0]     last;
  logic [NW-1:0]     idx_nx;
  logic [SLOT_W-1:0] nxt;
  logic [NW-1:0]     mc_n;
  logic              mc_wb;
  logic [SLOT_W-1:0] mc_s0;

  // Unused slot positions read as zero so idx never indexes past the array.
  for (genvar k = 0; k < NS; k++) begin : g_slot
    if (k < NUM_SLOTS) begin : g_on
      assign slot[k] = word[k*SLOT_W +: SLOT_W];
    end else begin : g_off
      assign slot[k] = '0;
    end
  end

  assign word_n  = word[MICROCODE_WIDTH-1 -: NW];
  assign word_wb = word[MICROCODE_WIDTH-NW-1];
  assign last    = word_n - ONE;
  assign idx_nx  = idx + ONE;
  assign nxt     = slot[idx_nx];

  assign mc_n  = mc_word[MICROCODE_WIDTH-1 -: NW];
  assign mc_wb = mc_word[MICROCODE_WIDTH-NW-1];
  assign mc_s0 = mc_word[SLOT_W-1:0];

  assign mc_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      idx       <= '0;
      cnt       <= '0;
      uop_valid <= 1'b0;
      uop_op    <= '0;
      uop_row   <= '0;
      uop_first <= 1'b0;
      done      <= 1'b0;
      wb_en     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      done    <= 1'b0;
      wb_en   <= 1'b0;
      illegal <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        word      <= '0;
        idx       <= '0;
        cnt       <= '0;
        uop_valid <= 1'b0;
        uop_op    <= '0;
        uop_row   <= '0;
        uop_first <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (mc_valid) begin
              word <= mc_word;
              idx  <= '0;
              if (mc_n == '0) begin
                state <= DONE;
                done  <= 1'b1;
                wb_en <= mc_wb;
              end else if (mc_n > NMAX) begin
                state   <= DONE;
                done    <= 1'b1;
                illegal <= 1'b1;
              end else begin
                state     <= ISSUE;
                cnt       <= mc_s0[3:0];
                uop_valid <= 1'b1;
                uop_op    <= mc_s0[11:8];
                uop_row   <= mc_s0[7:4];
                uop_first <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (!uop_stall) begin
              if (cnt != 4'd0) begin
                cnt       <= cnt - 4'd1;
                uop_first <= 1'b0;
              end else if (idx == last) begin
                state     <= DONE;
                idx       <= '0;
                uop_valid <= 1'b0;
                uop_op    <= '0;
                uop_row   <= '0;
                uop_first <= 1'b0;
                done      <= 1'b1;
                wb_en     <= word_wb;
              end else begin
                idx       <= idx_nx;
                cnt       <= nxt[3:0];
                uop_op    <= nxt[11:8];
                uop_row   <= nxt[7:4];
                uop_first <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomized bench for microcode_sequencer against a queue-based model
// of the expected micro-op stream.
module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mc_valid;
  logic [63:0] mc_word;
  logic        mc_ready;
  logic        flush;
  logic        uop_valid;
  logic [3:0]  uop_op;
  logic [3:0]  uop_row;
  logic        uop_first;
  logic        uop_stall;
  logic        done;
  logic        wb_en;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] S1 = 64'h5000_0000_0052_2310;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk(clk), .rst(rst),
    .mc_valid(mc_valid), .mc_word(mc_word), .mc_ready(mc_ready),
    .flush(flush),
    .uop_valid(uop_valid), .uop_op(uop_op), .uop_row(uop_row),
    .uop_first(uop_first), .uop_stall(uop_stall),
    .done(done), .wb_en(wb_en), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // kind: 0 none, 1 flush, 2 reset, applied in uop cycle abort_at
  task automatic run(input logic [63:0] w, input logic [63:0] smask,
                     input int spct, input int abort_at, input int kind,
                     input int exp_lat);
    logic [8:0]  q[$];
    logic [11:0] s;
    logic        st;
    int          n;
    int          cyc;
    n = int'(w[63:61]);
    chk("ready_idle", 64'(mc_ready), 64'(1));
    mc_valid = 1'b1;
    mc_word  = w;
    @(negedge clk);
    mc_valid = 1'b0;
    mc_word  = {$urandom, $urandom};
    if (n == 0 || n > 5) begin
      chk("done_short", 64'(done), 64'(1));
      chk("illegal", 64'(illegal), 64'(n > 5));
      chk("wb_short", 64'(wb_en), 64'((n > 5) ? 1'b0 : w[60]));
      chk("uv_short", 64'(uop_valid), 64'(0));
      chk("ready_short", 64'(mc_ready), 64'(0));
      @(negedge clk);
      chk("ready_after", 64'(mc_ready), 64'(1));
      chk("done_after", 64'(done), 64'(0));
      chk("illegal_after", 64'(illegal), 64'(0));
      return;
    end
    for (int k = 0; k < n; k++) begin
      s = w[k*12 +: 12];
      for (int r = 0; r <= int'(s[3:0]); r++)
        q.push_back({s[11:8], s[7:4], r == 0});
    end
    cyc = 0;
    while (q.size() > 0) begin
      if (cyc > 3000) begin
        chk("timeout_left", 64'(q.size()), 64'(0));
        return;
      end
      chk("uv", 64'(uop_valid), 64'(1));
      chk("uop", 64'({uop_op, uop_row, uop_first}), 64'(q[0]));
      chk("done_mid", 64'(done), 64'(0));
      chk("ready_mid", 64'(mc_ready), 64'(0));
      if (kind != 0 && cyc == abort_at) begin
        if (kind == 1) flush = 1'b1;
        else rst = 1'b1;
        uop_stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        flush = 1'b0;
        rst = 1'b0;
        uop_stall = 1'b0;
        chk("uv_abort", 64'(uop_valid), 64'(0));
        chk("done_abort", 64'(done), 64'(0));
        chk("ready_abort", 64'(mc_ready), 64'(1));
        chk("wb_abort", 64'(wb_en), 64'(0));
        if (kind == 2)
          chk("uop_rst", 64'({uop_op, uop_row, uop_first, illegal}), 64'(0));
        return;
      end
      st = (cyc < 64 && smask[cyc]) || ($urandom_range(0, 99) < spct);
      uop_stall = st;
      @(negedge clk);
      uop_stall = 1'b0;
      if (!st) void'(q.pop_front());
      cyc++;
    end
    chk("done", 64'(done), 64'(1));
    chk("wb", 64'(wb_en), 64'(w[60]));
    chk("uv_done", 64'(uop_valid), 64'(0));
    chk("illegal_done", 64'(illegal), 64'(0));
    chk("ready_done", 64'(mc_ready), 64'(0));
    if (exp_lat >= 0) chk("latency", 64'(cyc + 1), 64'(exp_lat));
    @(negedge clk);
    chk("ready_post", 64'(mc_ready), 64'(1));
    chk("done_post", 64'(done), 64'(0));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    int          kind;
    rst = 1'b1;
    mc_valid = 1'b0;
    mc_word = '0;
    flush = 1'b0;
    uop_stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(mc_ready), 64'(1));
    chk("rst_outs", 64'({uop_valid, uop_op, uop_row, uop_first,
                         done, wb_en, illegal}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run(S1, 64'h0, 0, -1, 0, 5);
    run(S1, 64'h6, 0, -1, 0, 7);
    run(64'h0, 64'h0, 0, -1, 0, -1);
    run(64'hC000_0000_0000_0000, 64'h0, 0, -1, 0, -1);
    run(S1, 64'h0, 0, 2, 1, -1);
    run(S1, 64'h0, 0, -1, 0, 5);
    run(S1, 64'h0, 0, 1, 2, -1);
    run(64'hB000_0000_0000_0000, 64'h0, 0, -1, 0, -1);

    // flush beats a simultaneous word in IDLE
    mc_valid = 1'b1;
    mc_word = S1;
    flush = 1'b1;
    @(negedge clk);
    mc_valid = 1'b0;
    flush = 1'b0;
    chk("fv_ready", 64'(mc_ready), 64'(1));
    chk("fv_uv", 64'(uop_valid), 64'(0));
    chk("fv_done", 64'(done), 64'(0));
    @(negedge clk);
    chk("fv_uv2", 64'(uop_valid), 64'(0));

    for (int i = 0; i < 150; i++) begin
      w = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) w[63:61] = 3'($urandom_range(1, 5));
      kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      run(w, 64'h0, int'($urandom_range(0, 50)),
          int'($urandom_range(0, 12)), kind, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
